// File: rtl/simd_regfile_decode.sv
// Decode / register-read stage of the SIMD unit: 32x128 register file with
// three combinational read ports and one write-back port. Macro: RF_WB_BYPASS_EN.
module simd_regfile_decode #(
    parameter int unsigned DW   = 128,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = $clog2(NREG),
    parameter int unsigned IW   = 25
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] instr,
    input  logic          instr_vld,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [IW-1:0] opcode,
    output logic          opcode_vld,
    output logic [DW-1:0] d1out,
    output logic [DW-1:0] d2out,
    output logic [DW-1:0] d3out,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] r_mem [NREG];

    logic          w_is_li;
    logic          w_is_r4;
    logic [AW-1:0] w_a1;
    logic [AW-1:0] w_a2;
    logic [AW-1:0] w_a3;

    // Register array: reset wins over a same-cycle write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_mem[i] <= '0;
            end
        end else if (wb_en) begin
            r_mem[wb_addr] <= wb_data;
        end
    end

    // Array read, optionally forwarding the in-flight write-back (write-first).
    function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] a);
`ifdef RF_WB_BYPASS_EN
        if (wb_en && !rst && (a == wb_addr)) begin
            return wb_data;
        end
`endif
        return r_mem[a];
    endfunction

    assign w_is_li = ~instr[24];
    assign w_is_r4 = (instr[24:23] == 2'b10);
    assign w_a1    = w_is_li ? instr[4:0] : instr[9:5];
    assign w_a2    = instr[14:10];
    assign w_a3    = instr[19:15];

    always_comb begin
        d1out = '0;
        d2out = '0;
        d3out = '0;
        if (instr_vld) begin
            d1out = rd_port(w_a1);
            if (w_is_li) begin
                // Immediate and halfword index are zero-extended operands.
                d2out = DW'(instr[20:5]);
                d3out = DW'(instr[23:21]);
            end else begin
                d2out = rd_port(w_a2);
                if (w_is_r4) begin
                    d3out = rd_port(w_a3);
                end
            end
        end
    end

    assign opcode     = instr;
    assign opcode_vld = instr_vld;
    assign dbg_data   = r_mem[dbg_addr];

endmodule

// File: tb/tb_simd_regfile_decode.sv
// Self-checking bench for simd_regfile_decode: directed cases then random
// traffic checked against a behavioural register-file model.
module tb_simd_regfile_decode;
    localparam int unsigned DW   = 128;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned IW   = 25;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] instr;
    logic          instr_vld;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] dbg_addr;
    logic [IW-1:0] opcode;
    logic          opcode_vld;
    logic [DW-1:0] d1out;
    logic [DW-1:0] d2out;
    logic [DW-1:0] d3out;
    logic [DW-1:0] dbg_data;

    logic [DW-1:0] m [NREG];
    int unsigned   n_chk  = 0;
    int unsigned   n_fail = 0;

    always #5 clk = ~clk;

    simd_regfile_decode dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .instr_vld  (instr_vld),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .dbg_addr   (dbg_addr),
        .opcode     (opcode),
        .opcode_vld (opcode_vld),
        .d1out      (d1out),
        .d2out      (d2out),
        .d3out      (d3out),
        .dbg_data   (dbg_data)
    );

    function automatic logic [IW-1:0] mk_r3(input logic [4:0] rs2, input logic [4:0] rs1);
        return {2'b11, 8'd0, rs2, rs1, 5'd0};
    endfunction

    function automatic logic [IW-1:0] mk_r4(input logic [4:0] rs3, input logic [4:0] rs2,
                                            input logic [4:0] rs1);
        return {2'b10, 3'd0, rs3, rs2, rs1, 5'd0};
    endfunction

    function automatic logic [IW-1:0] mk_li(input logic [2:0] idx, input logic [15:0] imm,
                                            input logic [4:0] rd);
        return {1'b0, idx, imm, rd};
    endfunction

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Architectural view of a register read this cycle.
    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
`ifdef RF_WB_BYPASS_EN
        if (wb_en && !rst && a == wb_addr) return wb_data;
`endif
        return m[a];
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model for the current inputs.
    task automatic check_all(input string ctx);
        logic [DW-1:0] e1, e2, e3;
        e1 = '0; e2 = '0; e3 = '0;
        #1;
        if (instr_vld) begin
            case (instr[24:23])
                2'b10: begin
                    e1 = model_read(instr[9:5]);
                    e2 = model_read(instr[14:10]);
                    e3 = model_read(instr[19:15]);
                end
                2'b11: begin
                    e1 = model_read(instr[9:5]);
                    e2 = model_read(instr[14:10]);
                end
                default: begin
                    e1 = model_read(instr[4:0]);
                    e2 = {112'd0, instr[20:5]};
                    e3 = {125'd0, instr[23:21]};
                end
            endcase
        end
        chk({ctx, ".d1"}, d1out, e1);
        chk({ctx, ".d2"}, d2out, e2);
        chk({ctx, ".d3"}, d3out, e3);
        chk({ctx, ".opcode"}, DW'(opcode), DW'(instr));
        chk({ctx, ".opcode_vld"}, DW'(opcode_vld), DW'(instr_vld));
        chk({ctx, ".dbg"}, dbg_data, m[dbg_addr]);
    endtask

    // Advance one clock; the model commits what the DUT sampled.
    task automatic clk_edge();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) m[i] = '0;
        end else if (wb_en) begin
            m[wb_addr] = wb_data;
        end
        #1;
    endtask

    initial begin
        logic [DW-1:0] c_aa, c_0123, c_ones, v_old, v_new;
        c_aa   = {16{8'hAA}};
        c_0123 = {2{64'h0123456789ABCDEF}};
        c_ones = '1;
        for (int i = 0; i < int'(NREG); i++) m[i] = '0;

        rst = 1'b1; instr = mk_r3(5'd0, 5'd0); instr_vld = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; dbg_addr = '0;
        clk_edge();
        rst = 1'b0;
        check_all("after_reset");
        chk("after_reset.d1_zero", d1out, '0);

        // Preloaded value is cleared by a one-cycle reset pulse.
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = c_aa;
        clk_edge();
        wb_en = 1'b0; dbg_addr = 5'd5;
        check_all("preload");
        chk("preload.dbg5", dbg_data, c_aa);
        rst = 1'b1;
        clk_edge();
        rst = 1'b0; instr = mk_r3(5'd0, 5'd5);
        check_all("rst_pulse");
        chk("rst_pulse.d1", d1out, '0);
        chk("rst_pulse.dbg5", dbg_data, '0);

        // Write then read R7 through all three R4 ports.
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = c_0123;
        clk_edge();
        wb_en = 1'b0; instr = mk_r4(5'd7, 5'd7, 5'd7);
        check_all("r4_read");
        chk("r4_read.d1", d1out, c_0123);
        chk("r4_read.d2", d2out, c_0123);
        chk("r4_read.d3", d3out, c_0123);

        // Load-immediate decode.
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = c_ones;
        clk_edge();
        wb_en = 1'b0; instr = mk_li(3'd6, 16'h1234, 5'd2);
        check_all("load_imm");
        chk("load_imm.d1", d1out, c_ones);
        chk("load_imm.d2", d2out, 128'h1234);
        chk("load_imm.d3", d3out, 128'd6);

        // Same-cycle write-back to a register being read on two ports.
        v_old = rnd128(); v_new = ~v_old;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = v_old;
        clk_edge();
        wb_data = v_new; instr = mk_r3(5'd9, 5'd9); dbg_addr = 5'd9;
        check_all("bypass");
`ifdef RF_WB_BYPASS_EN
        chk("bypass.d1", d1out, v_new);
        chk("bypass.d2", d2out, v_new);
`else
        chk("bypass.d1", d1out, v_old);
        chk("bypass.d2", d2out, v_old);
`endif
        chk("bypass.dbg9", dbg_data, v_old);
        clk_edge();
        wb_en = 1'b0;
        check_all("post_write");
        chk("post_write.d1", d1out, v_new);

        // Reset overrides a simultaneous write-back.
        rst = 1'b1; wb_en = 1'b1; wb_addr = 5'd1; wb_data = rnd128();
        instr = mk_r3(5'd1, 5'd1);
        check_all("rst_vs_wb");
        clk_edge();
        rst = 1'b0; wb_en = 1'b0; dbg_addr = 5'd1;
        check_all("rst_vs_wb_after");
        chk("rst_vs_wb.d1", d1out, '0);
        chk("rst_vs_wb.dbg1", dbg_data, '0);

        // Bubble forces operands to zero but passes the opcode.
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = c_0123;
        clk_edge();
        wb_en = 1'b0; instr_vld = 1'b0; instr = mk_r3(5'd7, 5'd7);
        check_all("bubble");
        chk("bubble.d1", d1out, '0);
        chk("bubble.d2", d2out, '0);
        chk("bubble.d3", d3out, '0);
        chk("bubble.opcode", DW'(opcode), DW'(mk_r3(5'd7, 5'd7)));
        chk("bubble.opcode_vld", DW'(opcode_vld), '0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 49) == 0);
            wb_en     = ($urandom_range(0, 2) != 0);
            wb_addr   = AW'($urandom);
            wb_data   = rnd128();
            instr     = IW'($urandom);
            instr_vld = ($urandom_range(0, 7) != 0);
            dbg_addr  = AW'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                instr[4:0]   = wb_addr;
                instr[9:5]   = wb_addr;
                instr[14:10] = wb_addr;
                instr[19:15] = wb_addr;
            end
            check_all("random");
            clk_edge();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
